// File: rtl/serial_adder_if.sv
// Handshake bundle for serial_adder: operand input channel and result output channel.
// SERIAL_ADDER_OVERFLOW_EN adds the out_overflow signal.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             out_overflow;
`endif

  modport master (
    output in_valid, in_a, in_b, in_carry, out_ready,
`ifdef SERIAL_ADDER_OVERFLOW_EN
    input  out_overflow,
`endif
    input  in_ready, out_valid, out_sum, out_carry
  );

  modport slave (
    input  in_valid, in_a, in_b, in_carry, out_ready,
`ifdef SERIAL_ADDER_OVERFLOW_EN
    output out_overflow,
`endif
    output in_ready, out_valid, out_sum, out_carry
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder plus a registered carry, LSB first.
// Define SERIAL_ADDER_OVERFLOW_EN to add the signed-overflow output.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);
  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  serial_adder_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_sum, fa_cout;

  full_adder u_fa (
    .a        (a_sr_q[0]),
    .b        (b_sr_q[0]),
    .carry_in (carry_q),
    .sum      (fa_sum),
    .carry_out(fa_cout)
  );

`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sr_d  = bus.in_a;
          b_sr_d  = bus.in_b;
          carry_d = bus.in_carry;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        // Shift-then-insert keeps this legal for WIDTH=1 (no zero-width slice).
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = fa_sum;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
`ifdef SERIAL_ADDER_OVERFLOW_EN
          ovf_d   = carry_q;
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_carry = carry_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  // Carry into the MSB xor carry out of it is the two's-complement overflow.
  assign bus.out_overflow = ovf_q ^ carry_q;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and WIDTH=1.
// Overflow checks compile in when SERIAL_ADDER_OVERFLOW_EN is defined.
module tb_serial_adder;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   n;
  logic seen;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(1)) if1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand pair on the 8-bit DUT and wait for the result; leaves it in DONE.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] exp_sum, input logic exp_c, input logic exp_ovf);
    int lat;
    if8.in_a = a; if8.in_b = b; if8.in_carry = c; if8.in_valid = 1'b1;
    check({tag, "_ready"}, 64'(if8.in_ready), 64'd1);
    tick();
    if8.in_valid = 1'b0;
    lat = 0;
    while (!if8.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd8);
    check({tag, "_sum"}, 64'(if8.out_sum), 64'(exp_sum));
    check({tag, "_carry"}, 64'(if8.out_carry), 64'(exp_c));
`ifdef SERIAL_ADDER_OVERFLOW_EN
    check({tag, "_ovf"}, 64'(if8.out_overflow), 64'(exp_ovf));
`else
    if (exp_ovf !== exp_ovf) $display("unreachable");
`endif
  endtask

  task automatic release8();
    if8.out_ready = 1'b1;
    tick();
    if8.out_ready = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    if8.in_valid = 0; if8.in_a = '0; if8.in_b = '0; if8.in_carry = 0; if8.out_ready = 0;
    if1.in_valid = 0; if1.in_a = '0; if1.in_b = '0; if1.in_carry = 0; if1.out_ready = 0;
    rst = 1'b1;
    #12;
    check("rst_in_ready", 64'(if8.in_ready), 64'd1);
    check("rst_out_valid", 64'(if8.out_valid), 64'd0);
    check("rst_out_sum", 64'(if8.out_sum), 64'd0);
    check("rst_out_carry", 64'(if8.out_carry), 64'd0);
    rst = 1'b0;
    tick();

    run8("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);

    // Backpressure: result held while out_ready=0, new pair waits.
    if8.in_a = 8'h33; if8.in_b = 8'h44; if8.in_carry = 1'b0; if8.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_in_ready", 64'(if8.in_ready), 64'd0);
      check("bp_out_valid", 64'(if8.out_valid), 64'd1);
      check("bp_sum", 64'(if8.out_sum), 64'h10);
      check("bp_carry", 64'(if8.out_carry), 64'd0);
    end
    if8.out_ready = 1'b1;
    tick();
    if8.out_ready = 1'b0;
    check("bp_idle_ready", 64'(if8.in_ready), 64'd1);
    check("bp_sum_kept", 64'(if8.out_sum), 64'h10);
    tick();
    if8.in_valid = 1'b0;
    check("bp_accepted", 64'(if8.in_ready), 64'd0);
    n = 0;
    while (!if8.out_valid && n < 20) begin tick(); n++; end
    check("bp_new_latency", 64'(n), 64'd8);
    check("bp_new_sum", 64'(if8.out_sum), 64'h77);
    release8();

    run8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    release8();

    // Back-to-back with out_ready high: next accept 10 edges after the first.
    if8.out_ready = 1'b1;
    if8.in_a = 8'hFF; if8.in_b = 8'h01; if8.in_carry = 1'b0; if8.in_valid = 1'b1;
    tick();
    check("b2b_first_taken", 64'(if8.in_ready), 64'd0);
    if8.in_a = 8'hFF; if8.in_b = 8'hFF; if8.in_carry = 1'b1;
    n = 0; seen = 1'b0;
    while (!if8.in_ready && n < 30) begin
      tick();
      n++;
      if (if8.out_valid) begin
        seen = 1'b1;
        check("b2b_first_sum", 64'(if8.out_sum), 64'h00);
        check("b2b_first_carry", 64'(if8.out_carry), 64'd1);
      end
    end
    check("b2b_first_seen", 64'(seen), 64'd1);
    check("b2b_ready_edge", 64'(n), 64'd9);
    tick();
    if8.in_valid = 1'b0;
    n = 0;
    while (!if8.out_valid && n < 20) begin tick(); n++; end
    check("b2b_second_latency", 64'(n), 64'd8);
    check("b2b_second_sum", 64'(if8.out_sum), 64'hFF);
    check("b2b_second_carry", 64'(if8.out_carry), 64'd1);
    tick();
    if8.out_ready = 1'b0;
    check("b2b_idle", 64'(if8.in_ready), 64'd1);

    // Reset in the middle of RUN discards the partial result.
    if8.in_a = 8'hAA; if8.in_b = 8'h55; if8.in_carry = 1'b0; if8.in_valid = 1'b1;
    tick();
    if8.in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #2;
    check("midrst_ready", 64'(if8.in_ready), 64'd1);
    check("midrst_sum", 64'(if8.out_sum), 64'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (if8.out_valid) seen = 1'b1;
    end
    check("midrst_no_valid", 64'(seen), 64'd0);
    check("midrst_idle", 64'(if8.in_ready), 64'd1);
    run8("add_01_02", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
    release8();

`ifdef SERIAL_ADDER_OVERFLOW_EN
    run8("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    release8();
    run8("ovf_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    release8();
    run8("ovf_01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
    release8();
`endif

    // WIDTH=1: exhaustive over a, b, cin.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] exp;
      v = 3'(i);
      exp = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      if1.in_a = v[2]; if1.in_b = v[1]; if1.in_carry = v[0]; if1.in_valid = 1'b1;
      check("w1_ready", 64'(if1.in_ready), 64'd1);
      tick();
      if1.in_valid = 1'b0;
      check("w1_busy", 64'(if1.out_valid), 64'd0);
      tick();
      check("w1_valid", 64'(if1.out_valid), 64'd1);
      check("w1_result", 64'({if1.out_carry, if1.out_sum}), 64'(exp));
      if1.out_ready = 1'b1;
      tick();
      if1.out_ready = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
